// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
//  Module : common_pkg
//  Brief  : Shared sizing constants, feeder FSM state and input row type for
//           the systolic-array feeding logic.
//  Rev    : 1.0  initial release
// ============================================================================
package common_pkg;

  localparam int SYS_ARRAY_SIZE = 4;
  localparam int DATA_WIDTH     = 8;

  // Feeder control states: accept/stream slices, then drain the skew so two
  // products never overlap inside the array.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_e;

  // One buffered row pair; the FIFO word layout {a, b, last} follows it.
  typedef struct packed {
    logic [SYS_ARRAY_SIZE*DATA_WIDTH-1:0] a;
    logic [SYS_ARRAY_SIZE*DATA_WIDTH-1:0] b;
    logic                                 last;
  } in_row_t;

  // Width of a packed {a, b, last} word for an n-lane, dw-bit feeder.
  function automatic int row_width(input int n, input int dw);
    return 2 * n * dw + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module : sync_fifo
//  Brief  : Single-clock show-ahead FIFO. dout always presents the oldest
//           entry; pushes while full and pops while empty are ignored.
//  Rev    : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  // No same-cycle bypass: a push is only taken when there is room now.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy tracking; DEPTH is a power of two so the pointers
  // wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  // Storage array; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module : systolic_skew_feeder
//  Brief  : Buffers A-column / B-row slices and launches them into an NxN
//           systolic array with a diagonal skew (lane i delayed by i cycles).
//           After the last slice of a product the feeder drains for N cycles
//           so consecutive products never overlap in the array.
//  Rev    : 1.0  initial release
// ============================================================================
module systolic_skew_feeder
  import common_pkg::*;
#(
  parameter int N     = SYS_ARRAY_SIZE,
  parameter int DW    = DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_a,
  input  logic [N*DW-1:0] in_b,
  input  logic            in_last,
  output logic [N*DW-1:0] out_a,
  output logic [N*DW-1:0] out_b,
  output logic [N-1:0]    out_vld,
  output logic [N-1:0]    out_last,
  output logic            done,
  output logic            busy
);

  localparam int RW = row_width(N, DW);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] DRAIN_CYCLES = CW'(N);

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [RW-1:0]          fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count_unused;
  logic                   push;
  logic                   pop;
  logic [N*DW-1:0]        pop_a;
  logic [N*DW-1:0]        pop_b;
  logic                   pop_last;

  feeder_state_e          state_q;
  feeder_state_e          state_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;

  // ---------------------------------------------------------------- input --
  assign in_ready = rst_n && !fifo_full;
  assign push     = in_valid && in_ready && !flush;
  // Nothing leaves the buffer while a product is draining out of the skew.
  assign pop      = !fifo_empty && (state_q != DRAIN) && !flush;

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({in_a, in_b, in_last}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  assign pop_a    = fifo_dout[RW-1 -: N*DW];
  assign pop_b    = fifo_dout[RW-1-N*DW -: N*DW];
  assign pop_last = fifo_dout[0];

  // ----------------------------------------------------------------- skew --
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_q [i+1];
    logic [DW-1:0] b_q [i+1];
    logic [i:0]    vld_q;
    logic [i:0]    last_q;

    // Stage 0 captures this lane's slice of the popped row (or a zero
    // bubble); stages 1..i add the diagonal delay.
    always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
        for (int s = 0; s <= i; s++) begin
          a_q[s] <= '0;
          b_q[s] <= '0;
        end
        vld_q  <= '0;
        last_q <= '0;
      end else begin
        if (pop) begin
          a_q[0]    <= pop_a[i*DW +: DW];
          b_q[0]    <= pop_b[i*DW +: DW];
          vld_q[0]  <= 1'b1;
          last_q[0] <= pop_last;
        end else begin
          a_q[0]    <= '0;
          b_q[0]    <= '0;
          vld_q[0]  <= 1'b0;
          last_q[0] <= 1'b0;
        end
        for (int s = 1; s <= i; s++) begin
          a_q[s]    <= a_q[s-1];
          b_q[s]    <= b_q[s-1];
          vld_q[s]  <= vld_q[s-1];
          last_q[s] <= last_q[s-1];
        end
      end
    end

    assign out_a[i*DW +: DW] = a_q[i];
    assign out_b[i*DW +: DW] = b_q[i];
    assign out_vld[i]        = vld_q[i];
    assign out_last[i]       = last_q[i];
  end

  // ------------------------------------------------------------------ fsm --
  // State register with the drain cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: the last slice leaving the FIFO starts an N-cycle drain,
  // followed by one done cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = pop_last ? DRAIN : STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (pop && pop_last) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_CYCLES) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: done lands one cycle after lane N-1 presents its last marker.
  always_comb begin
    done = (state_q == DRAIN) && (cnt_q == DRAIN_CYCLES);
    busy = (state_q != IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module : tb_systolic_skew_feeder
//  Brief  : Scoreboard bench. A queue-based reference model predicts, for each
//           popped slice, the cycle and lane where it must appear and when
//           done must pulse; a monitor compares every cycle at the negedge.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_systolic_skew_feeder;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int W     = N * DW;
  localparam int N8    = 8;
  localparam int DW8   = 16;
  localparam int W8    = N8 * DW8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, in_valid, in_last, in_ready, done, busy;
  logic [W-1:0]  in_a, in_b, out_a, out_b;
  logic [N-1:0]  out_vld, out_last;

  logic          in_valid8, in_last8, in_ready8, done8, busy8;
  logic [W8-1:0] in_a8, in_b8, out_a8, out_b8;
  logic [N8-1:0] out_vld8, out_last8;

  systolic_skew_feeder #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_a(out_a), .out_b(out_b), .out_vld(out_vld), .out_last(out_last),
    .done(done), .busy(busy)
  );

  systolic_skew_feeder #(.N(N8), .DW(DW8), .DEPTH(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid8),
    .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8), .in_last(in_last8),
    .out_a(out_a8), .out_b(out_b8), .out_vld(out_vld8), .out_last(out_last8),
    .done(done8), .busy(busy8)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         last;
  } row_t;

  typedef struct {
    int            cyc;
    int            lane;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          last;
  } exp_t;

  row_t mq[$];      // model of buffered slices
  exp_t eq[$];      // expected lane appearances
  int   dq[$];      // expected done cycles
  int   cyc      = 0;
  int   m_drain  = 0;
  bit   m_stream = 1'b0;
  bit   started  = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input bit ok, input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h, required %0h", nm, cyc, act, req);
  endtask

  function automatic bit model_idle();
    return mq.size() == 0 && eq.size() == 0 && dq.size() == 0 &&
           !m_stream && m_drain == 0;
  endfunction

  // Reference model: evaluates the cycle ending at this edge.
  always @(posedge clk) begin
    row_t r;
    exp_t e;
    bit   acc;
    if (!rst_n || flush) begin
      if (!rst_n) started = 1'b1;
      mq.delete(); eq.delete(); dq.delete();
      m_drain  = 0;
      m_stream = 1'b0;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      if (mq.size() > 0 && m_drain == 0) begin
        r = mq.pop_front();
        for (int i = 0; i < N; i++) begin
          e.cyc  = cyc + 1 + i;
          e.lane = i;
          e.a    = r.a[i*DW +: DW];
          e.b    = r.b[i*DW +: DW];
          e.last = r.last;
          eq.push_back(e);
        end
        if (r.last) begin
          m_drain  = N + 1;
          m_stream = 1'b0;
          dq.push_back(cyc + N + 1);
        end else begin
          m_stream = 1'b1;
        end
      end else if (m_drain > 0) begin
        m_drain--;
      end
      if (acc) begin
        r.a = in_a; r.b = in_b; r.last = in_last;
        mq.push_back(r);
      end
    end
    cyc++;
  end

  // Monitor: pops due expectations and compares every output each cycle.
  always @(negedge clk) begin
    int              idx;
    logic [2*DW+1:0] act, req;
    bit              dexp;
    if (started) begin
      for (int i = 0; i < N; i++) begin
        idx = -1;
        for (int k = 0; k < eq.size(); k++)
          if (eq[k].lane == i && eq[k].cyc == cyc) idx = k;
        act = {out_vld[i], out_last[i], out_a[i*DW +: DW], out_b[i*DW +: DW]};
        if (idx >= 0) req = {1'b1, eq[idx].last, eq[idx].a, eq[idx].b};
        else          req = '0;
        chk(act === req, $sformatf("lane%0d", i), act, req);
      end
      for (int k = eq.size() - 1; k >= 0; k--)
        if (eq[k].cyc <= cyc) eq.delete(k);
      dexp = 1'b0;
      for (int k = dq.size() - 1; k >= 0; k--) begin
        if (dq[k] == cyc) begin dexp = 1'b1; dq.delete(k); end
        else if (dq[k] < cyc) dq.delete(k);
      end
      chk(done === dexp, "done", done, dexp);
      chk(busy === (m_stream || m_drain > 0), "busy", busy, (m_stream || m_drain > 0));
      chk(in_ready === (rst_n && mq.size() < DEPTH), "in_ready", in_ready,
          (rst_n && mq.size() < DEPTH));
    end
  end

  task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit l, input bit f, input bit r);
    @(posedge clk);
    #1;
    in_valid = v; in_a = a; in_b = b; in_last = l; flush = f; rst_n = r;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rnd_slice(input bit l);
    logic [W-1:0] a, b;
    a = $urandom();
    b = $urandom();
    step(1'b1, a, b, l, 1'b0, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!model_idle() && k < budget) begin
      idle();
      k++;
    end
    chk(k < budget, "wait_idle", k, budget);
  endtask

  // Wide instance: one slice with last=1 must walk lanes 0..7 then pulse done.
  task automatic run8();
    logic [W8-1:0] a, b, ea, eb;
    logic [N8-1:0] ev;
    a = '0; b = '0;
    for (int i = 0; i < N8; i++) begin
      a[i*DW8 +: DW8] = 16'hA000 + 16'(i + 1);
      b[i*DW8 +: DW8] = 16'hB000 + 16'(i + 1);
    end
    @(posedge clk);
    #1;
    in_valid8 = 1'b1; in_a8 = a; in_b8 = b; in_last8 = 1'b1;
    for (int k = 0; k <= N8 + 3; k++) begin
      @(negedge clk);
      ev = '0; ea = '0; eb = '0;
      for (int i = 0; i < N8; i++) begin
        if (k == i + 2) begin
          ev[i] = 1'b1;
          ea[i*DW8 +: DW8] = a[i*DW8 +: DW8];
          eb[i*DW8 +: DW8] = b[i*DW8 +: DW8];
        end
      end
      chk(out_vld8 === ev, "n8_vld", out_vld8, ev);
      chk(out_last8 === ev, "n8_last", out_last8, ev);
      chk(out_a8 === ea, "n8_a", out_a8, ea);
      chk(out_b8 === eb, "n8_b", out_b8, eb);
      chk(done8 === (k == N8 + 2), "n8_done", done8, (k == N8 + 2));
      chk(busy8 === (k >= 2 && k <= N8 + 2), "n8_busy", busy8, (k >= 2 && k <= N8 + 2));
      if (k == 0) begin
        chk(in_ready8 === 1'b1, "n8_ready", in_ready8, 1'b1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0; in_last8 = 1'b0; in_a8 = '0; in_b8 = '0;
      end
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0;
    in_valid8 = 1'b0; in_last8 = 1'b0; in_a8 = '0; in_b8 = '0;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle();

    run8();
    wait_idle(20);

    // Single slice with last: lanes at t+2..t+5, done at t+6.
    step(1'b1, 32'h04030201, 32'h08070605, 1'b1, 1'b0, 1'b1);
    idle();
    wait_idle(20);

    // Six back-to-back slices of one product.
    for (int i = 0; i < 6; i++) rnd_slice(i == 5);
    idle();
    wait_idle(30);

    // Two products offered back to back.
    for (int i = 0; i < 4; i++) rnd_slice(i == 3);
    for (int i = 0; i < 3; i++) rnd_slice(i == 2);
    idle();
    wait_idle(40);

    // Fill the buffer while draining, including one push while full.
    rnd_slice(1'b1);
    for (int i = 0; i < 5; i++) rnd_slice(1'b0);
    idle();

    // The buffered non-last slices now stream; flush with two still queued.
    k = 0;
    while (!(m_stream && mq.size() == 2) && k < 40) begin
      idle();
      k++;
    end
    chk(k < 40, "flush_point", k, 40);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    idle();
    rnd_slice(1'b1);
    idle();
    wait_idle(20);

    // Reset while draining.
    rnd_slice(1'b0);
    rnd_slice(1'b1);
    k = 0;
    while (m_drain == 0 && k < 20) begin
      idle();
      k++;
    end
    chk(k < 20, "drain_point", k, 20);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle();
    idle();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a, b;
      a = $urandom();
      b = $urandom();
      step($urandom_range(0, 9) < 6, a, b, $urandom_range(0, 4) == 0,
           $urandom_range(0, 99) == 0, 1'b1);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    idle();
    wait_idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 SHALL have parameter N, default SYS_ARRAY_SIZE (4), systolic array edge size and lane count.
REQ-002 SHALL have parameter DW, default DATA_WIDTH (8), element width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, input FIFO entries; power of 2, at least 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port flush, input, 1, synchronous clear of FIFO, skew pipeline and FSM.
REQ-007 SHALL have port in_valid, input, 1, a row pair is offered.
REQ-008 SHALL have port in_ready, output, 1, the feeder can accept a row pair.
REQ-009 SHALL have port in_a, input, N*DW, A column slice; lane i = bits [i*DW +: DW].
REQ-010 SHALL have port in_b, input, N*DW, B row slice, same packing.
REQ-011 SHALL have port in_last, input, 1, final slice of the current matrix product.
REQ-012 SHALL have port out_a, output, N*DW, skewed A lanes into the array's west edge.
REQ-013 SHALL have port out_b, output, N*DW, skewed B lanes into the array's north edge.
REQ-014 SHALL have port out_vld, output, N, per-lane valid.
REQ-015 SHALL have port out_last, output, N, per-lane last marker, skewed with its lane.
REQ-016 SHALL have port done, output, 1, one-cycle pulse after the last slice leaves lane N-1.
REQ-017 SHALL have port busy, output, 1, high in every FSM state except IDLE.

Function
REQ-018 Accept: a row pair is written to the FIFO when in_valid && in_ready; in_ready = !full, with no same-cycle bypass when full.
REQ-019 Simultaneous push and pop SHALL keep the count unchanged; pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-020 Pop: one entry per cycle when FIFO not empty and state is IDLE or STREAM; no pop in DRAIN.
REQ-021 Skew: an entry popped in cycle p SHALL appear on lane i (out_a, out_b, out_vld=1, out_last) in cycle p+1+i; lane 0 is a register stage and lane i adds i further stages.
REQ-022 Bubbles: in a cycle with no pop, the lane-0 stage SHALL load data 0, vld 0 and last 0; invalid lanes SHALL drive data 0.
REQ-023 Latency: with the FIFO empty in IDLE, a slice accepted in cycle t SHALL appear on lane 0 at t+2 and lane N-1 at t+N+1.
REQ-024 FSM IDLE -> STREAM on the first pop; STREAM -> DRAIN on popping an entry with last=1; IDLE also goes straight to DRAIN if that first pop has last=1.
REQ-025 DRAIN SHALL count N cycles with a counter of clog2(N)+1 bits, then pulse done for one cycle and return to IDLE; this guarantees no two products overlap in the array.
REQ-026 DRAIN end: done SHALL coincide with the cycle after lane N-1 shows out_last=1.
REQ-027 flush SHALL take priority over push, pop and FSM: next cycle FIFO empty, all lanes vld=0 and data 0, state IDLE, done=0; an in_valid during flush is dropped.
REQ-028 Data SHALL pass through bit-exact; there is no arithmetic on data paths.

Reset
REQ-029 When rst_n=0 at a clock edge: FIFO pointers and count 0, in_ready=0 during reset and 1 from the next cycle, state IDLE, out_a/out_b/out_vld/out_last all 0, done=0, busy=0.
REQ-030 Reset mid-stream SHALL discard all buffered and in-flight slices with no done pulse.

Structure
REQ-031 A feeder state enum (IDLE, STREAM, DRAIN) and an in_row_t struct {a, b, last} sized from SYS_ARRAY_SIZE and DATA_WIDTH SHALL be added to common_pkg.
REQ-032 The input buffer SHALL be a separate sub-module, sync_fifo (parameters WIDTH and DEPTH; push/pop/full/empty/count); the skew pipeline and FSM stay in the top module.

Verification
REQ-033 N=4: push one slice a=0x04030201, b=0x08070605, last=1 at t=0 -> lane0 0x01/0x05 at t=2 through lane3 0x04/0x08 at t=5, out_last on each lane with its data, done at t=6.
REQ-034 Push 6 back-to-back slices with DEPTH=4 and lanes never stalled -> in_ready never low, and lane 0 shows 6 consecutive valid cycles in push order.
REQ-035 Push 4 slices with the last one carrying last=1, then immediately offer 3 slices of a second product -> the second product's first lane-0 valid comes no earlier than the cycle after done.
REQ-036 With the FSM held in DRAIN, push until full -> in_ready drops at count=4, and a push attempt while full is not stored and the FIFO count stays 4.
REQ-037 Assert flush for 1 cycle mid-STREAM with 2 entries buffered -> next cycle out_vld=0000, busy=0, no done pulse, and a fresh slice afterwards meets REQ-023 latency.
REQ-038 Assert rst_n=0 during DRAIN -> all outputs 0 the next cycle and no done pulse; rerun REQ-033 with N=8 and DW=16 for the parametrised check.
